// File: rtl/lpc_model_store_pkg.sv
// Shared constants and dump-FSM state encoding for the LPC coefficient store.
package lpc_model_store_pkg;

  localparam int          IDX_W      = 4;
  localparam int          LPC_ORDER  = 12;
  localparam logic [31:0] LPC_FP_ONE = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } dump_state_e;

endpackage

// File: rtl/lpc_model_regfile.sv
// Coefficient storage: prioritised multi-source writes and three combinational read ports.
module lpc_model_regfile
  import lpc_model_store_pkg::*;
#(
  parameter int          ORDER  = LPC_ORDER,
  parameter logic [31:0] FP_ONE = LPC_FP_ONE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] target1_i,
  input  logic [IDX_W-1:0] target2_i,
  input  logic [31:0]      data1_i,
  input  logic [31:0]      data2_i,
  input  logic             only_one_i,
  input  logic             set_k_i,
  input  logic [IDX_W-1:0] k_idx_i,
  input  logic [31:0]      k_i,
  input  logic [IDX_W-1:0] sel1_i,
  input  logic [IDX_W-1:0] sel2_i,
  input  logic [IDX_W-1:0] sel3_i,
  output logic [31:0]      rd1_o,
  output logic [31:0]      rd2_o,
  output logic [31:0]      rd3_o
);

  logic [31:0] mem_q [0:ORDER];
  logic [31:0] mem_d [0:ORDER];
  logic        p1_s;
  logic        p2_s;
  logic        k_s;

  assign p1_s = wr_en_i & we_i;
  assign p2_s = wr_en_i & we_i & ~only_one_i;
  assign k_s  = wr_en_i & set_k_i;

  // Next-state of every entry; entry 0 is excluded from port writes and the
  // if-chain order encodes port1 > port2 > iSetK on a shared index.
  always_comb begin
    mem_d[0] = clear_i ? FP_ONE : mem_q[0];
    for (int i = 1; i <= ORDER; i++) begin
      if (clear_i) begin
        mem_d[i] = 32'h0000_0000;
      end else if (p1_s && (target1_i == IDX_W'(i))) begin
        mem_d[i] = data1_i;
      end else if (p2_s && (target2_i == IDX_W'(i))) begin
        mem_d[i] = data2_i;
      end else if (k_s && (k_idx_i == IDX_W'(i))) begin
        mem_d[i] = k_i;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= FP_ONE;
      for (int i = 1; i <= ORDER; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i <= ORDER; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read muxes; an address beyond ORDER matches nothing and reads zero.
  always_comb begin
    rd1_o = 32'h0000_0000;
    rd2_o = 32'h0000_0000;
    rd3_o = 32'h0000_0000;
    for (int i = 0; i <= ORDER; i++) begin
      rd1_o = (sel1_i == IDX_W'(i)) ? mem_q[i] : rd1_o;
      rd2_o = (sel2_i == IDX_W'(i)) ? mem_q[i] : rd2_o;
      rd3_o = (sel3_i == IDX_W'(i)) ? mem_q[i] : rd3_o;
    end
  end

endmodule

// File: rtl/lpc_model_store.sv
// Levinson-Durbin coefficient bank with a valid/ready coefficient dump to the quantiser.
module lpc_model_store
  import lpc_model_store_pkg::*;
#(
  parameter int          ORDER  = LPC_ORDER,
  parameter logic [31:0] FP_ONE = LPC_FP_ONE
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iClear,
  input  logic             iSetK,
  input  logic [IDX_W-1:0] iKIdx,
  input  logic [31:0]      iK,
  input  logic [IDX_W-1:0] iSel1,
  input  logic [IDX_W-1:0] iSel2,
  output logic [31:0]      oModel1,
  output logic [31:0]      oModel2,
  input  logic             iWe,
  input  logic [IDX_W-1:0] iTarget1,
  input  logic [IDX_W-1:0] iTarget2,
  input  logic [31:0]      iData1,
  input  logic [31:0]      iData2,
  input  logic             iOnlyOne,
  input  logic             iDumpStart,
  input  logic [IDX_W-1:0] iDumpOrder,
  output logic [31:0]      oCoef,
  output logic [IDX_W-1:0] oCoefIdx,
  output logic             oCoefValid,
  input  logic             iCoefReady,
  output logic             oDumpDone,
  output logic             oBusy,
  output logic             oWriteErr
);

  localparam logic [IDX_W-1:0] ORDER_IDX = IDX_W'(ORDER);

  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] order_q, order_d;
  logic [31:0]      coef_q, coef_d;
  logic [IDX_W-1:0] coef_idx_q, coef_idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_s;
  logic [31:0]      dump_data_s;

  assign busy_s = (state_q != ST_IDLE);

  lpc_model_regfile #(
    .ORDER  (ORDER),
    .FP_ONE (FP_ONE)
  ) u_regfile (
    .clk        (iClock),
    .rst        (iReset),
    .clear_i    (iClear),
    .wr_en_i    (~busy_s),
    .we_i       (iWe),
    .target1_i  (iTarget1),
    .target2_i  (iTarget2),
    .data1_i    (iData1),
    .data2_i    (iData2),
    .only_one_i (iOnlyOne),
    .set_k_i    (iSetK),
    .k_idx_i    (iKIdx),
    .k_i        (iK),
    .sel1_i     (iSel1),
    .sel2_i     (iSel2),
    .sel3_i     (idx_q),
    .rd1_o      (oModel1),
    .rd2_o      (oModel2),
    .rd3_o      (dump_data_s)
  );

  // Dump FSM next state, stream outputs and sticky write-error flag.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    order_d    = order_q;
    coef_d     = coef_q;
    coef_idx_d = coef_idx_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = err_q | (busy_s & (iWe | iSetK));
    if (iClear) begin
      state_d    = ST_IDLE;
      idx_d      = {IDX_W{1'b0}};
      order_d    = {IDX_W{1'b0}};
      coef_d     = 32'h0000_0000;
      coef_idx_d = {IDX_W{1'b0}};
      valid_d    = 1'b0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iDumpStart && (iDumpOrder == {IDX_W{1'b0}})) begin
            done_d = 1'b1;
          end else if (iDumpStart) begin
            order_d = (iDumpOrder > ORDER_IDX) ? ORDER_IDX : iDumpOrder;
            idx_d   = {{(IDX_W-1){1'b0}}, 1'b1};
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          coef_d     = dump_data_s;
          coef_idx_d = idx_q;
          valid_d    = 1'b1;
          state_d    = ST_SEND;
        end
        ST_SEND: begin
          // Dropping valid on every handshake gives the one-cycle bubble between beats.
          if (iCoefReady && (idx_q < order_q)) begin
            idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            valid_d = 1'b0;
            state_d = ST_LOAD;
          end else if (iCoefReady) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      order_q    <= {IDX_W{1'b0}};
      coef_q     <= 32'h0000_0000;
      coef_idx_q <= {IDX_W{1'b0}};
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      order_q    <= order_d;
      coef_q     <= coef_d;
      coef_idx_q <= coef_idx_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign oCoef      = coef_q;
  assign oCoefIdx   = coef_idx_q;
  assign oCoefValid = valid_q;
  assign oDumpDone  = done_q;
  assign oBusy      = busy_s;
  assign oWriteErr  = err_q;

endmodule
